fetch_prefetch_buffer: RTL and testbench

Instruction prefetch stage that sits between the fetch/PC logic and decode. It issues sequential word fetches to a synchronous instruction memory with 1-cycle read latency. Returned instructions, each tagged with its PC, go into a small FIFO and are presented to decode through a valid/ready handshake. A redirect input from branch resolution flushes the buffer, squashes any in-flight fetch, and restarts fetch at the target.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_prefetch_buffer_sync_fifo.sv | 45 ++++
 rtl/fetch_prefetch_buffer.sv | 90 +++++++++
 tb/tb_fetch_prefetch_buffer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction prefetch buffer.
package fetch_pkg;
   localparam int          XLEN        = 32;
   localparam int          INSTR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/fetch_prefetch_buffer_sync_fifo.sv
// Small synchronous FIFO with synchronous flush and an occupancy count.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_pop;

   assign do_pop   = pop && (count != '0);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !do_pop)      count <= count + 1'b1;
         else if (!push && do_pop) count <= count - 1'b1;
      end
   end
endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Sequential instruction prefetcher feeding decode through a small FIFO.
// Optional same-cycle bypass of memory data to decode: define PREFETCH_BYPASS_EN.
module fetch_prefetch_buffer
   import fetch_pkg::*;
#(
   parameter int                    DATA_WIDTH = XLEN,
   parameter int                    DEPTH      = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  instr_valid,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] instr_pc,
   input  logic                  instr_ready
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [DATA_WIDTH-1:0] fetch_pc;
   logic [DATA_WIDTH-1:0] inflight_pc;
   logic                  inflight;
   logic [CNT_W-1:0]      count;
   logic [CNT_W:0]        used;
   logic                  resp_ok;
   logic                  push;
   logic                  pop;
   fetch_entry_t          wr_entry;
   fetch_entry_t          head;

   // Credit rule: never have more outstanding than free FIFO slots.
   assign used      = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
   assign imem_req  = !rst && !redirect && (used < (CNT_W+1)'(DEPTH));
   assign imem_addr = fetch_pc;
   assign resp_ok   = inflight && !redirect;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else if (redirect) begin
         fetch_pc <= align_pc(redirect_pc);
         inflight <= 1'b0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            fetch_pc    <= fetch_pc + DATA_WIDTH'(INSTR_BYTES);
            inflight_pc <= fetch_pc;
         end
      end
   end

   always_comb begin
      wr_entry.pc    = inflight_pc;
      wr_entry.instr = imem_rdata;
      instr_valid    = (count != '0);
      instr          = head.instr;
      instr_pc       = head.pc;
      push           = resp_ok;
`ifdef PREFETCH_BYPASS_EN
      // Empty buffer: hand the arriving word straight to decode.
      if (resp_ok && (count == '0)) begin
         instr_valid = 1'b1;
         instr       = imem_rdata;
         instr_pc    = inflight_pc;
         push        = !instr_ready;
      end
`endif
      pop = (count != '0) && instr_ready;
   end

   sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect),
      .push      (push),
      .push_data (wr_entry),
      .pop       (pop),
      .pop_data  (head),
      .count     (count)
   );
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer (default and wrap-around RESET_PC instances).
module tb_fetch_prefetch_buffer;
   localparam logic [31:0] MASK = 32'hA5A5_0000;
`ifdef PREFETCH_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        instr_ready = 1'b0;
   logic        imem_req, instr_valid;
   logic [31:0] imem_addr, imem_rdata, instr, instr_pc;
   logic        redirect_w = 1'b0;
   logic [31:0] redirect_pc_w = '0;
   logic        imem_req_w, instr_valid_w;
   logic [31:0] imem_addr_w, imem_rdata_w, instr_w, instr_pc_w;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // One-cycle-latency instruction memories
   always @(posedge clk) begin
      imem_rdata   <= imem_addr ^ MASK;
      imem_rdata_w <= imem_addr_w ^ MASK;
   end

   fetch_prefetch_buffer dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready)
   );

   fetch_prefetch_buffer #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
      .clk(clk), .rst(rst), .redirect(redirect_w), .redirect_pc(redirect_pc_w),
      .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
      .instr_valid(instr_valid_w), .instr(instr_w), .instr_pc(instr_pc_w),
      .instr_ready(instr_ready)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; redirect = 1'b0; instr_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", instr_valid); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", imem_req); end
      n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", imem_addr); end
      n_checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_head got %h/%h want 0/0", instr, instr_pc); end
      n_checks++; if (imem_addr_w !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL reset_addr_w got %h want fffffff8", imem_addr_w); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_stream();
      instr_ready = 1'b1;
      for (int c = 0; c < LAT + 8; c++) begin
         @(negedge clk);
         n_checks++;
         if (instr_valid !== (c >= LAT)) begin n_fail++; $display("FAIL stream_valid c=%0d got %b want %b", c, instr_valid, c >= LAT); end
         if (c >= LAT) begin
            n_checks++;
            if (instr_pc !== 32'((c - LAT) * 4) || instr !== (32'((c - LAT) * 4) ^ MASK)) begin
               n_fail++; $display("FAIL stream_data c=%0d got %h/%h want %h", c, instr_pc, instr, 32'((c - LAT) * 4));
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_stall();
      logic [31:0] exp_pc;
      int gap;
      rst = 1'b1; instr_ready = 1'b0;
      next_cycle();
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 3) begin
            n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_req_c3 got %b want 1", imem_req); end
         end
         if (c == 9) begin
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_full got %b want 0", imem_req); end
            n_checks++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL stall_addr got %h want 10", imem_addr); end
            n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== MASK) begin
               n_fail++; $display("FAIL stall_head got %b %h/%h want 1 0/%h", instr_valid, instr_pc, instr, MASK);
            end
         end
         next_cycle();
      end
      instr_ready = 1'b1;
      exp_pc = 32'h0; gap = 0;
      for (int c = 0; c < 20 && exp_pc < 32'h20; c++) begin
         @(negedge clk);
         if (instr_valid === 1'b1) begin
            n_checks++;
            if (instr_pc !== exp_pc || instr !== (exp_pc ^ MASK)) begin n_fail++; $display("FAIL drain_data got %h/%h want %h", instr_pc, instr, exp_pc); end
            exp_pc += 4; gap = 0;
         end else begin
            gap++;
            n_checks++; if (gap > 2) begin n_fail++; $display("FAIL drain_gap got %0d idle cycles want <=2", gap); end
         end
         next_cycle();
      end
      n_checks++; if (exp_pc !== 32'h20) begin n_fail++; $display("FAIL drain_count got next pc %h want 20", exp_pc); end
   endtask

   task automatic expect_restart(input logic [31:0] base, input string name);
      for (int k = 0; k < LAT + 4; k++) begin
         @(negedge clk);
         if (k == 0) begin
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== base) begin n_fail++; $display("FAIL %s_addr got %b %h want 1 %h", name, imem_req, imem_addr, base); end
         end
         n_checks++; if (instr_valid !== (k >= LAT)) begin n_fail++; $display("FAIL %s_valid k=%0d got %b want %b", name, k, instr_valid, k >= LAT); end
         if (k >= LAT) begin
            n_checks++;
            if (instr_pc !== base + 32'((k - LAT) * 4) || instr !== ((base + 32'((k - LAT) * 4)) ^ MASK)) begin
               n_fail++; $display("FAIL %s_data k=%0d got %h/%h want %h", name, k, instr_pc, instr, base + 32'((k - LAT) * 4));
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_redirect();
      rst = 1'b1; instr_ready = 1'b0;
      next_cycle();
      rst = 1'b0;
      repeat (4) next_cycle();
      redirect = 1'b1; redirect_pc = 32'h100; instr_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req got %b want 0", imem_req); end
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin n_fail++; $display("FAIL redir_head got %b %h want 1 0", instr_valid, instr_pc); end
      next_cycle();
      redirect = 1'b0;
      expect_restart(32'h100, "redir");
   endtask

   task automatic test_misaligned();
      redirect = 1'b1; redirect_pc = 32'h103;
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL misal_req got %b want 0", imem_req); end
      next_cycle();
      redirect = 1'b0;
      expect_restart(32'h100, "misal");
   endtask

   task automatic test_back_to_back();
      redirect = 1'b1; redirect_pc = 32'h200;
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_req0 got %b want 0", imem_req); end
      next_cycle();
      redirect_pc = 32'h300;
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL b2b_req1 got %b %h want 0 200", imem_req, imem_addr); end
      next_cycle();
      redirect = 1'b0;
      expect_restart(32'h300, "b2b");
   endtask

   task automatic test_async_reset_wrap();
      logic [31:0] wpc;
      @(negedge clk);
      n_checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b1) begin n_fail++; $display("FAIL pre_rst got %b %b want 1 1", instr_valid, imem_req); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL async_rst got %b %b want 0 0", instr_valid, imem_req); end
      n_checks++; if (imem_addr !== 32'h0 || instr_valid_w !== 1'b0) begin n_fail++; $display("FAIL async_rst_addr got %h %b want 0 0", imem_addr, instr_valid_w); end
      next_cycle();
      rst = 1'b0;
      for (int c = 0; c < LAT + 4; c++) begin
         @(negedge clk);
         n_checks++; if (instr_valid_w !== (c >= LAT)) begin n_fail++; $display("FAIL wrap_valid c=%0d got %b want %b", c, instr_valid_w, c >= LAT); end
         if (c >= LAT) begin
            wpc = 32'hFFFF_FFF8 + 32'((c - LAT) * 4);
            n_checks++; if (instr_pc_w !== wpc || instr_w !== (wpc ^ MASK)) begin n_fail++; $display("FAIL wrap_data c=%0d got %h/%h want %h", c, instr_pc_w, instr_w, wpc); end
            n_checks++; if (instr_pc !== 32'((c - LAT) * 4)) begin n_fail++; $display("FAIL rst_restart c=%0d got %h want %h", c, instr_pc, 32'((c - LAT) * 4)); end
         end
         next_cycle();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_misaligned();
      test_back_to_back();
      test_async_reset_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
